// File: rtl/memory_access_stage_pkg.sv
// rtl/memory_access_stage_pkg.sv - shared pipeline opcodes, MEM-stage state type and helpers
package memory_access_stage_pkg;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;

  localparam logic [4:0] OP_LW = 5'd0;
  localparam logic [4:0] OP_SW = 5'd1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_wb_register.sv
// rtl/mem_wb_register.sv - MEM/WB boundary register: one-cycle valid pulse, payload held until next load
module mem_wb_register #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] in_instruction,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0] in_mem_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_instruction,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0] out_mem_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_instruction <= '0;
      out_data        <= '0;
      out_mem_data    <= '0;
    end else begin
      out_valid <= load;
      if (load) begin
        out_instruction <= in_instruction;
        out_data        <= in_data;
        out_mem_data    <= in_mem_data;
      end
    end
  end

endmodule

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - MEM pipeline stage: LW/SW over a req/ack memory, stalls EX/MEM while busy
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_instruction,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_store_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_instruction,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0] out_mem_data,
  output logic                  err_timeout,
  output logic                  err_misaligned
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  mem_state_e state, next_state;
  logic [7:0] wait_cnt;
  logic [DATA_WIDTH-1:0] lat_instruction;
  logic [4:0] in_op;
  logic accept, in_is_mem, in_aligned, start_access, limit_hit;
  logic wb_load;
  logic [DATA_WIDTH-1:0] wb_instruction, wb_data, wb_mem_data;

  // mem_req comes straight from the state flop so an async reset drops it at once
  assign in_ready     = (state == IDLE);
  assign mem_req      = (state == WAIT);
  assign in_op        = in_instruction[OPCODE_MSB:OPCODE_LSB];
  assign accept       = in_valid && in_ready;
  assign in_is_mem    = is_mem_op(in_op);
  assign in_aligned   = (in_alu_result[1:0] == 2'b00);
  assign start_access = accept && in_is_mem && in_aligned;
  assign limit_hit    = (state == WAIT) && !mem_ack && (wait_cnt == LIMIT);

  always_comb begin
    next_state     = state;
    wb_load        = 1'b0;
    wb_instruction = in_instruction;
    wb_data        = in_alu_result;
    wb_mem_data    = '0;
    case (state)
      IDLE: begin
        if (start_access) begin
          next_state = WAIT;
        end else if (accept) begin
          wb_load = 1'b1;
        end
      end
      WAIT: begin
        wb_instruction = lat_instruction;
        wb_data        = mem_addr;
        if (mem_ack) begin
          next_state  = IDLE;
          wb_load     = 1'b1;
          wb_mem_data = mem_we ? '0 : mem_rdata;
        end else if (limit_hit) begin
          next_state = IDLE;
          wb_load    = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      lat_instruction <= '0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      err_timeout     <= 1'b0;
      err_misaligned  <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == WAIT) && !mem_ack && !limit_hit) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= '0;
      end
      if (start_access) begin
        lat_instruction <= in_instruction;
        mem_we          <= (in_op == OP_SW);
        mem_addr        <= in_alu_result;
        mem_wdata       <= in_store_data;
      end
      if (limit_hit) begin
        err_timeout <= 1'b1;
      end
      if (accept && in_is_mem && !in_aligned) begin
        err_misaligned <= 1'b1;
      end
    end
  end

  mem_wb_register #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem_wb_register (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (wb_load),
    .in_instruction (wb_instruction),
    .in_data        (wb_data),
    .in_mem_data    (wb_mem_data),
    .out_valid      (out_valid),
    .out_instruction(out_instruction),
    .out_data       (out_data),
    .out_mem_data   (out_mem_data)
  );

endmodule
